seq_mac8: RTL and testbench

SEQ_MAC8 -- requirements
Module: seq_mac8

---
 rtl/seq_mac8.sv | 133 +++++++++++++
 tb/tb_seq_mac8.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mac8.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mac8
//  Purpose  : Sequential shift-add 8x8 unsigned multiplier with early exit
//             and an optional wrapping 20-bit product accumulator.
//  Revision : 1.0
// ============================================================================
module seq_mac8 #(
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product,
    output logic [ACC_W-1:0] acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [2*W-1:0]     mcand_q,   mcand_d;
    logic [W-1:0]       mult_q,    mult_d;
    logic [2*W-1:0]     psum_q,    psum_d;
    logic               acc_en_q,  acc_en_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [2*W-1:0]     product_q, product_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;

    logic [2*W-1:0]     addend;
    logic [2*W-1:0]     psum_sum;
    logic [ACC_W-1:0]   prod_ext;

    // Adder operand is gated to zero on a 0 multiplier bit so it does not toggle.
    assign addend   = mult_q[0] ? mcand_q : '0;
    assign psum_sum = psum_q + addend;
    assign prod_ext = ACC_W'(psum_sum);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        psum_d    = psum_q;
        acc_en_d  = acc_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        acc_d     = acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{W{1'b0}}, a};
                    mult_d   = b;
                    acc_en_d = acc_en;
                    psum_d   = '0;
                    state_d  = RUN;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (mult_q[0]) begin
                    psum_d = psum_sum;
                end
                mult_d  = mult_q >> 1;
                mcand_d = mcand_q << 1;
                // Exit once no set multiplier bits remain above the current one.
                if (mult_q[W-1:1] == '0) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = psum_sum;
                    if (acc_en_q) begin
                        acc_d = acc_q + prod_ext;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mult_q    <= '0;
            psum_q    <= '0;
            acc_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            psum_q    <= psum_d;
            acc_en_q  <= acc_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            acc_q     <= acc_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign acc     = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mac8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mac8
//  Purpose  : Directed, table-driven self-checking bench for seq_mac8.
//  Revision : 1.0
// ============================================================================
module tb_seq_mac8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc_en;
    logic        acc_clr;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [19:0] acc;

    int n_checks;
    int n_fail;

    seq_mac8 #(.W(8), .ACC_W(20)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .acc_en  (acc_en),
        .acc_clr (acc_clr),
        .busy    (busy),
        .done    (done),
        .product (product),
        .acc     (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        en;
        logic [15:0] prod;
        int          done_cyc;
        logic [19:0] acc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation at the next edge (cycle 0) and follows it to the IDLE cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ten,
                          input logic [15:0] ep, input int edone, input logic [19:0] eacc,
                          input string nm);
        int busy_cnt;
        int done_cyc;
        int done_cnt;
        a      = ta;
        b      = tb_v;
        acc_en = ten;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        a      = ~ta;
        b      = ~tb_v;
        acc_en = ~ten;
        busy_cnt = 0;
        done_cyc = 0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) break;
            tick();
        end
        check({nm, " done_cycle"}, done_cyc, edone);
        check({nm, " busy_cycles"}, busy_cnt, edone - 1);
        check({nm, " product"}, {16'h0, product}, {16'h0, ep});
        check({nm, " acc"}, {12'h0, acc}, {12'h0, eacc});
    endtask

    initial begin
        int          busy_cnt;
        int          done_cnt;
        logic [19:0] acc_m;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01, 9, 20'h0FE01};
        vecs[1] = '{8'h5A, 8'h01, 1'b1, 16'h005A, 2, 20'h0FE5B};
        vecs[2] = '{8'h77, 8'h00, 1'b1, 16'h0000, 2, 20'h0FE5B};
        vecs[3] = '{8'h03, 8'h10, 1'b1, 16'h0030, 6, 20'h0FE8B};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 16'h03A8, 7, 20'h0FE8B};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 16'h4000, 9, 20'h13E8B};
        vecs[6] = '{8'hAB, 8'h07, 1'b1, 16'h04AD, 4, 20'h14338};

        // Reset held with random inputs.
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; acc_en = 1'b0; acc_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start   = 1'($urandom);
            a       = 8'($urandom);
            b       = 8'($urandom);
            acc_en  = 1'($urandom);
            acc_clr = 1'($urandom);
        end
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst product", {16'h0, product}, 32'h0);
        check("rst acc", {12'h0, acc}, 32'h0);

        @(negedge clk);
        start = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || done) busy_cnt++;
        end
        check("post-rst activity", busy_cnt, 0);
        check("post-rst product", {16'h0, product}, 32'h0);
        check("post-rst acc", {12'h0, acc}, 32'h0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].prod,
                   vecs[i].done_cyc, vecs[i].acc, $sformatf("vec%0d", i));
        end

        // Standalone clear in IDLE.
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("idle clear acc", {12'h0, acc}, 32'h0);
        check("idle clear keeps product", {16'h0, product}, 32'h04AD);

        // Seventeen back-to-back full-width accumulations wrap the accumulator.
        acc_m = '0;
        for (int i = 0; i < 17; i++) begin
            acc_m = acc_m + 20'h0FE01;
            run_op(8'hFF, 8'hFF, 1'b1, 16'hFE01, 9, acc_m, $sformatf("wrap%0d", i));
        end
        check("wrap final acc", {12'h0, acc}, 32'h0DE11);

        // Start held high through RUN and DONE: only one operation.
        a = 8'h02; b = 8'h03; acc_en = 1'b1; start = 1'b1;
        tick();
        a = 8'hFF; b = 8'hFF;
        busy_cnt = 0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 4) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            tick();
        end
        check("held start done pulses", done_cnt, 1);
        check("held start busy cycles", busy_cnt, 2);
        check("held start product", {16'h0, product}, 32'h0006);
        check("held start acc", {12'h0, acc}, 32'h0DE17);

        // Clear colliding with the accumulate edge.
        a = 8'h10; b = 8'h01; acc_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("collide done", {31'h0, done}, 32'h1);
        check("collide product", {16'h0, product}, 32'h0010);
        check("collide acc", {12'h0, acc}, 32'h0);
        tick();

        run_op(8'h02, 8'h02, 1'b1, 16'h0004, 3, 20'h00004, "pre-abort");

        // Reset asserted in cycle 4 of a full-width operation.
        a = 8'hFF; b = 8'hFF; acc_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort product", {16'h0, product}, 32'h0);
        check("abort acc", {12'h0, acc}, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            #1;
        end
        check("abort no done", done_cnt, 0);

        // Start presented on the first edge after release.
        run_op(8'h0F, 8'h0F, 1'b1, 16'h00E1, 5, 20'h000E1, "post-abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
